// File: rtl/fft_pkg.sv
// Shared types and helpers for fft_bfly_sequencer: FSM encoding, the stage-port width
// and the in-place radix-2 DIF butterfly address generator (shifts and masks only).
package fft_pkg;

    localparam int LOG2N_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Fields are sized for the largest legal FFT (LOG2N = 10); callers slice them down.
    typedef struct packed {
        logic [9:0] a0;
        logic [9:0] a1;
        logic [9:0] tw;
    } bfly_addr_t;

    function automatic int stage_w(input int log2n);
        return $clog2(log2n + 1);
    endfunction

    function automatic bfly_addr_t bfly_addr(input logic [3:0] log2n,
                                             input logic [3:0] s,
                                             input logic [9:0] b);
        bfly_addr_t r;
        logic [3:0] sh;
        logic [9:0] span;
        logic [9:0] pos;
        logic [9:0] grp;
        sh   = log2n - s - 4'd1;
        span = 10'd1 << sh;
        pos  = b & (span - 10'd1);
        grp  = b >> sh;
        r.a0 = (grp << (sh + 4'd1)) | pos;
        r.a1 = r.a0 | span;
        r.tw = pos << s;
        return r;
    endfunction

endpackage

// File: rtl/fft_dly_line.sv
// Parameterized register shift line with asynchronous active-low clear; output is the
// input delayed by exactly DEPTH clock cycles.
module fft_dly_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sequencer.sv
// Sequences one shared radix-2 DIF butterfly over an in-place N-point FFT.
// Optional macro FFT_SEQ_SCALE_EN adds wr_scale (divide-by-2 per stage on write-back).
module fft_bfly_sequencer
    import fft_pkg::*;
#(
    parameter int  LOG2N    = LOG2N_DEF,
    parameter int  PIPE_LAT = 2,
    localparam int SW       = stage_w(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr0,
    output logic [LOG2N-1:0] rd_addr1,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr0,
    output logic [LOG2N-1:0] wr_addr1
`ifdef FFT_SEQ_SCALE_EN
    ,
    output logic             wr_scale
`endif
);

    localparam int BW = LOG2N - 1;
    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int DW = 1 + 2 * LOG2N;

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [BW-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    bfly_addr_t    addr_d;
    logic [DW-1:0] wr_bus;
    logic          unused_addr;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    b_d     = '0;
                end
            end
            ST_RUN: begin
                if (&b_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            // Holding reads off for PIPE_LAT cycles lets the last write of a stage land
            // just before the first read of the next one.
            ST_DRAIN: begin
                if (cnt_q == CW'(PIPE_LAT - 1)) begin
                    if (stage_q < SW'(LOG2N - 1)) begin
                        state_d = ST_RUN;
                        stage_d = stage_q + SW'(1);
                        b_d     = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stage_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        addr_d = bfly_addr(4'(LOG2N), 4'(stage_d), 10'(b_d));
    end

    assign unused_addr = ^addr_d;

    // Outputs are registered from the next state so they line up with the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            busy     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done     <= (state_d == ST_DONE);
            rd_en    <= (state_d == ST_RUN);
            rd_addr0 <= addr_d.a0[LOG2N-1:0];
            rd_addr1 <= addr_d.a1[LOG2N-1:0];
            tw_addr  <= addr_d.tw[LOG2N-2:0];
        end
    end

    assign stage = stage_q;

    fft_dly_line #(
        .W     (DW),
        .DEPTH (PIPE_LAT)
    ) u_wr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({rd_en, rd_addr0, rd_addr1}),
        .q_o   (wr_bus)
    );

    assign wr_en    = wr_bus[DW-1];
    assign wr_addr0 = wr_bus[2*LOG2N-1:LOG2N];
    assign wr_addr1 = wr_bus[LOG2N-1:0];

`ifdef FFT_SEQ_SCALE_EN
    assign wr_scale = wr_en;
`endif

endmodule
